// File: rtl/systolic_pkg.sv
// Shared types and constants for the FP16 systolic array edge logic.
package systolic_pkg;

    localparam int DATA_WIDTH_DEFAULT = 16;

    typedef logic [15:0] fp16_t;

    localparam fp16_t FP16_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        LOAD,
        FEED,
        DONE
    } feeder_state_e;

endpackage

// File: rtl/edge_skew_mux.sv
// Per-lane wavefront selector: picks element (t - LANE) of the lane's
// buffered vector, or FP16 zero when t falls outside the lane's window.
module edge_skew_mux
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int N          = 4,
    parameter int CNT_W      = $clog2(2*N),
    parameter int LANE       = 0
)(
    input  logic [N*DATA_WIDTH-1:0] lane_vec,
    input  logic [CNT_W-1:0]        t,
    output logic [DATA_WIDTH-1:0]   elem
);

    // Match t against each in-window position; nothing matches -> zero pad.
    always_comb begin
        elem = DATA_WIDTH'(FP16_ZERO);
        for (int k = 0; k < N; k++) begin
            if (t == CNT_W'(k + LANE)) begin
                elem = lane_vec[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/systolic_edge_feeder.sv
// Buffers one NxN A tile and one NxN B tile, then drives the array's west
// and north edges with a diagonally skewed, zero-padded wavefront.
// Optional build macro FEEDER_PERF_CNT_EN adds tile_count / stall_cycles.
module systolic_edge_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int N          = 4,
    parameter int CNT_W      = $clog2(2*N)
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_a_vec,
    input  logic [N*DATA_WIDTH-1:0] in_b_vec,
    input  logic                    start,
    output logic [N*DATA_WIDTH-1:0] edge_a,
    output logic [N*DATA_WIDTH-1:0] edge_b,
    output logic                    edge_valid,
    output logic                    busy,
    output logic                    done
`ifdef FEEDER_PERF_CNT_EN
    ,
    output logic [31:0]             tile_count,
    output logic [31:0]             stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);
    localparam logic [CNT_W-1:0] T_LAST   = CNT_W'(2*N - 2);

    feeder_state_e state, state_nx;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] t;
    logic [CNT_W-1:0] issue_t;
    logic             load_fire;
    logic             start_ok;
    logic             feed_last;
    logic             issue;

    // a_buf[i][k] = A[i][k]; b_buf[k][j] = B[k][j]
    logic [DATA_WIDTH-1:0]   a_buf [N][N];
    logic [DATA_WIDTH-1:0]   b_buf [N][N];
    logic [N*DATA_WIDTH-1:0] a_lane [N];
    logic [N*DATA_WIDTH-1:0] b_lane [N];
    logic [DATA_WIDTH-1:0]   a_sel [N];
    logic [DATA_WIDTH-1:0]   b_sel [N];

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:    if (start_ok)  state_nx = FEED;
            FEED:    if (feed_last) state_nx = DONE;
            DONE:    state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // State-decoded outputs and control strobes.
    always_comb begin
        in_ready  = (state == LOAD) && (count < CNT_FULL);
        busy      = (state != LOAD);
        load_fire = in_ready && in_valid;
        start_ok  = (state == LOAD) && start && (count == CNT_FULL);
        feed_last = (state == FEED) && (t == T_LAST);
        // The wavefront presented next cycle: t=0 on the start edge, t+1 while feeding.
        issue     = start_ok || ((state == FEED) && !feed_last);
        issue_t   = start_ok ? '0 : t + CNT_W'(1);
    end

    // Beat counter and feed counter; both return to zero on the way back to LOAD.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            t     <= '0;
        end else begin
            if (state == DONE) begin
                count <= '0;
            end else if (load_fire) begin
                count <= count + CNT_W'(1);
            end
            if (state == FEED) begin
                t <= t + CNT_W'(1);
            end else begin
                t <= '0;
            end
        end
    end

    // Tile buffer write: beat k fills column k of A and row k of B.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (load_fire && (count == CNT_W'(k))) begin
                for (int i = 0; i < N; i++) begin
                    a_buf[i][k] <= in_a_vec[i*DATA_WIDTH +: DATA_WIDTH];
                    b_buf[k][i] <= in_b_vec[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Present row i of A and column j of B as flat lane vectors to the selectors.
    always_comb begin
        a_lane = '{default: '0};
        b_lane = '{default: '0};
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                a_lane[i][k*DATA_WIDTH +: DATA_WIDTH] = a_buf[i][k];
                b_lane[i][k*DATA_WIDTH +: DATA_WIDTH] = b_buf[k][i];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        edge_skew_mux #(
            .DATA_WIDTH (DATA_WIDTH),
            .N          (N),
            .CNT_W      (CNT_W),
            .LANE       (g)
        ) u_mux_a (
            .lane_vec (a_lane[g]),
            .t        (issue_t),
            .elem     (a_sel[g])
        );

        edge_skew_mux #(
            .DATA_WIDTH (DATA_WIDTH),
            .N          (N),
            .CNT_W      (CNT_W),
            .LANE       (g)
        ) u_mux_b (
            .lane_vec (b_lane[g]),
            .t        (issue_t),
            .elem     (b_sel[g])
        );
    end

    // Registered edge outputs; zeros whenever no wavefront is issued.
    always_ff @(posedge clk) begin
        if (!reset) begin
            edge_a     <= '0;
            edge_b     <= '0;
            edge_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            edge_valid <= issue;
            done       <= feed_last;
            for (int i = 0; i < N; i++) begin
                edge_a[i*DATA_WIDTH +: DATA_WIDTH] <= issue ? a_sel[i] : '0;
                edge_b[i*DATA_WIDTH +: DATA_WIDTH] <= issue ? b_sel[i] : '0;
            end
        end
    end

`ifdef FEEDER_PERF_CNT_EN
    // Completed-tile count (wrapping) and full-buffer idle cycles (saturating).
    always_ff @(posedge clk) begin
        if (!reset) begin
            tile_count   <= '0;
            stall_cycles <= '0;
        end else begin
            if (state == DONE) begin
                tile_count <= tile_count + 32'd1;
            end
            if ((state == LOAD) && (count == CNT_FULL) && !start &&
                (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
